// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-gantry sequencer.
package f1_pkg;

  typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, TIMING} race_state_t;

  localparam logic [7:0]  LIGHTS_ALL = 8'hFF;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // One Fibonacci step: taps 16,14,13,11 feed back into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the random hold-delay source.
module lfsr16
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/f1_race_ctrl.sv
// Race-start sequencer: lamp countdown, hold, lights-out and reaction timing.
// Define RANDOM_DELAY_EN to draw the hold delay from an LFSR instead of FIXED_DELAY.
module f1_race_ctrl
  import f1_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned DELAY_W     = 7,
  parameter int unsigned FIXED_DELAY = 64,
  parameter int unsigned RT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trigger,
  input  logic            react,
  output logic [7:0]      lights,
  output logic            busy,
  output logic            rt_valid,
  output logic [RT_W-1:0] rt_cycles,
  output logic            jump_start
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned FIX_W  = $clog2(FIXED_DELAY + 1);
  localparam int unsigned HOLD_W = (DELAY_W > FIX_W) ? DELAY_W : FIX_W;

  race_state_t       state, state_d;
  logic [7:0]        lights_d;
  logic              busy_d, rt_valid_d, jump_d;
  logic [RT_W-1:0]   rt_cycles_d, rt_cnt, rt_cnt_d;
  logic [TICK_W-1:0] tick_cnt, tick_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d, hold_load;

`ifdef RANDOM_DELAY_EN
  logic [15:0]        lfsr_q;
  logic [DELAY_W-1:0] rnd;
  logic               lfsr_unused;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // A zero draw would mean an empty hold, so it is promoted to one cycle.
  assign rnd         = lfsr_q[DELAY_W-1:0];
  assign hold_load   = (rnd == '0) ? HOLD_W'(1) : HOLD_W'(rnd);
  assign lfsr_unused = ^lfsr_q;
`else
  assign hold_load = HOLD_W'(FIXED_DELAY);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    lights_d    = lights;
    tick_d      = tick_cnt;
    hold_d      = hold_cnt;
    rt_cnt_d    = rt_cnt;
    rt_cycles_d = rt_cycles;
    rt_valid_d  = 1'b0;
    jump_d      = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_d  = LIGHTS;
          lights_d = '0;
          tick_d   = '0;
        end
      end
      LIGHTS: begin
        if (react) begin
          jump_d   = 1'b1;
          lights_d = '0;
          state_d  = IDLE;
        end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
          tick_d   = '0;
          lights_d = {lights[6:0], 1'b1};
          if ({lights[6:0], 1'b1} == LIGHTS_ALL) begin
            state_d = HOLD;
            hold_d  = hold_load;
          end
        end else begin
          tick_d = tick_cnt + TICK_W'(1);
        end
      end
      HOLD: begin
        if (react) begin
          jump_d   = 1'b1;
          lights_d = '0;
          state_d  = IDLE;
        end else if (hold_cnt == HOLD_W'(1)) begin
          lights_d = '0;
          rt_cnt_d = '0;
          state_d  = TIMING;
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      TIMING: begin
        if (react) begin
          rt_cycles_d = rt_cnt;
          rt_valid_d  = 1'b1;
          state_d     = IDLE;
        end else if (rt_cnt != {RT_W{1'b1}}) begin
          rt_cnt_d = rt_cnt + RT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lights     <= '0;
      busy       <= 1'b0;
      rt_valid   <= 1'b0;
      rt_cycles  <= '0;
      jump_start <= 1'b0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      rt_cnt     <= '0;
    end else begin
      state      <= state_d;
      lights     <= lights_d;
      busy       <= busy_d;
      rt_valid   <= rt_valid_d;
      rt_cycles  <= rt_cycles_d;
      jump_start <= jump_d;
      tick_cnt   <= tick_d;
      hold_cnt   <= hold_d;
      rt_cnt     <= rt_cnt_d;
    end
  end

endmodule

// File: tb/tb_f1_race_ctrl.sv
// Scoreboard bench for f1_race_ctrl: planned output events vs observed output changes.
module tb_f1_race_ctrl;

  localparam int unsigned TD  = 4;
  localparam int unsigned FD  = 10;
  localparam int unsigned RTW = 4;
  localparam int unsigned DW  = 7;
  localparam int          LAMPS_T = 8 * TD;
  localparam int          RT_MAX  = (1 << RTW) - 1;

  localparam int EV_BUSY = 0, EV_LIGHTS = 1, EV_RTC = 2, EV_RTV = 3, EV_JUMP = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst, trigger, react;
  logic [7:0]     lights;
  logic           busy, rt_valid, jump_start;
  logic [RTW-1:0] rt_cycles;

  ev_t expq[$];
  int  cyc = 0;
  int  n_cmp = 0, n_bad = 0;
  int  m_rtc = 0;
  bit  mon_en = 1'b0;
  logic [7:0]     p_lights;
  logic           p_busy;
  logic [RTW-1:0] p_rtc;
  int  ff_cyc = 0;
  int  hold_seen[128];
  int  n_oor = 0;
  string kname[5] = '{"busy", "lights", "rt_cycles", "rt_valid", "jump_start"};

  f1_race_ctrl #(
    .TICK_DIV    (TD),
    .DELAY_W     (DW),
    .FIXED_DELAY (FD),
    .RT_W        (RTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .react      (react),
    .lights     (lights),
    .busy       (busy),
    .rt_valid   (rt_valid),
    .rt_cycles  (rt_cycles),
    .jump_start (jump_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RANDOM_DELAY_EN
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input logic [31:0] val);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s event: value %0h at cycle %0d, none expected",
               kname[kind], val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event %s: got %s=%0h at cycle %0d, expected %s=%0h at cycle %0d",
                 kname[kind], kname[kind], val, cyc, kname[e.kind], e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every visible output change or pulse is checked against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== p_busy) check_ev(EV_BUSY, 32'(busy));
      if (lights !== p_lights) check_ev(EV_LIGHTS, 32'(lights));
      if (rt_cycles !== p_rtc && rt_valid !== 1'b1) check_ev(EV_RTC, 32'(rt_cycles));
      if (rt_valid !== 1'b0) check_ev(EV_RTV, 32'(rt_cycles));
      if (jump_start !== 1'b0) check_ev(EV_JUMP, 32'(rt_cycles));
      if (lights == 8'hFF && p_lights != 8'hFF) ff_cyc = cyc;
      if (lights == 8'h00 && p_lights == 8'hFF && busy === 1'b1) begin
        if (cyc - ff_cyc >= 1 && cyc - ff_cyc <= 127) hold_seen[cyc - ff_cyc]++;
        else n_oor++;
      end
      p_busy   = busy;
      p_lights = lights;
      p_rtc    = rt_cycles;
    end
  end

  function automatic int lights_at(input int e, input int d, input int k);
    int n;
    if (k < e || k >= e + LAMPS_T + d) return 0;
    n = (k - e) / TD;
    if (n > 8) n = 8;
    return (1 << n) - 1;
  endfunction

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = 32'(val);
    e.cyc  = c;
    expq.push_back(e);
  endtask

  // Reference: expected events of a sequence entered at edge e, cut at edge c.
  task automatic plan(input int e, input int d, input bit is_reset, input int c);
    int t0, v;
    t0 = e + LAMPS_T + d;
    push(EV_BUSY, 1, e);
    for (int n = 1; n <= 8; n++)
      if (e + n * TD < c) push(EV_LIGHTS, (1 << n) - 1, e + n * TD);
    if (t0 < c) push(EV_LIGHTS, 0, t0);
    push(EV_BUSY, 0, c);
    if (is_reset) begin
      if (lights_at(e, d, c - 1) != 0) push(EV_LIGHTS, 0, c);
      if (m_rtc != 0) push(EV_RTC, 0, c);
      m_rtc = 0;
    end else if (c <= t0) begin
      if (lights_at(e, d, c - 1) != 0) push(EV_LIGHTS, 0, c);
      push(EV_JUMP, m_rtc, c);
    end else begin
      v = c - t0 - 1;
      if (v > RT_MAX) v = RT_MAX;
      push(EV_RTV, v, c);
      m_rtc = v;
    end
  endtask

  task automatic tick(input logic t, input logic r);
    trigger = t;
    react   = r;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    react   = 1'b0;
  endtask

  // mode 0: react param cycles after lights-out; 1: react at entry+param; 2: reset at entry+param.
  task automatic run_seq(input int mode, input int param, input bit trig_react);
    int e, d, c, p;
`ifdef RANDOM_DELAY_EN
    logic [15:0] s;
`endif
    repeat ($urandom_range(1, 4)) tick(1'b0, 1'($urandom_range(0, 1)));
    e = cyc + 1;
`ifdef RANDOM_DELAY_EN
    s = m_lfsr;
    repeat (LAMPS_T) s = lfsr_step(s);
    d = int'(s[DW-1:0]);
    if (d == 0) d = 1;
`else
    d = FD;
`endif
    p = param;
    case (mode)
      0: begin
        if (p < 1) p = $urandom_range(1, 25);
        c = e + LAMPS_T + d + p;
      end
      1: begin
        if (p < 1) p = $urandom_range(1, LAMPS_T + d);
        c = e + p;
      end
      default: begin
        if (p < 1) p = $urandom_range(1, LAMPS_T + d + 10);
        c = e + p;
      end
    endcase
    plan(e, d, mode == 2, c);
    tick(1'b1, trig_react);
    for (int k = e + 1; k < c; k++) tick(1'($urandom_range(0, 3) == 0), 1'b0);
    if (mode == 2) begin
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0);
      rst = 1'b0;
    end else begin
      tick(1'b0, 1'b1);
    end
  endtask

  initial begin
    int distinct;
    rst = 1'b1;
    trigger = 1'b0;
    react = 1'b0;
    foreach (hold_seen[i]) hold_seen[i] = 0;
    repeat (3) tick(1'b0, 1'b0);
    rst = 1'b0;
    chk("reset lights", 32'(lights), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset rt_valid", 32'(rt_valid), 32'h0);
    chk("reset jump_start", 32'(jump_start), 32'h0);
    chk("reset rt_cycles", 32'(rt_cycles), 32'h0);
    p_busy   = busy;
    p_lights = lights;
    p_rtc    = rt_cycles;
    mon_en   = 1'b1;

    run_seq(0, 6, 1'b0);
    run_seq(1, 3 * TD + 2, 1'b0);
    run_seq(0, 20, 1'b1);
    run_seq(2, LAMPS_T + 3, 1'b0);
    run_seq(0, 6, 1'b0);
    run_seq(0, 9, 1'b0);
    run_seq(2, LAMPS_T + FD + 4, 1'b0);
    run_seq(0, 6, 1'b0);
    run_seq(1, 1, 1'b0);

`ifdef RANDOM_DELAY_EN
    for (int i = 0; i < 100; i++) run_seq(0, -1, 1'($urandom_range(0, 1)));
`endif
    for (int i = 0; i < 25; i++) run_seq($urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));

    repeat (5) tick(1'b0, 1'b0);
    chk("scoreboard drained", 32'(expq.size()), 32'h0);
`ifdef RANDOM_DELAY_EN
    distinct = 0;
    foreach (hold_seen[i]) if (hold_seen[i] != 0) distinct++;
    chk("hold lengths outside 1..127", 32'(n_oor), 32'h0);
    chk("distinct hold lengths >= 10", 32'(distinct >= 10), 32'h1);
`else
    distinct = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
